// File: rtl/regfile_2w2r_sb.sv
// regfile_2w2r_sb
//   Register file with two write ports, two combinational read ports and a
//   busy scoreboard that has one bit per register. It sits between decode,
//   which does the reads and reservations, and writeback, which does the
//   writes.
//
//   Parameters
//     num_bit_of_data : register width in bits
//     num_bit_of_addr : address width; depth is 2**num_bit_of_addr
//     ZERO_REG        : 1 makes r0 read as zero. Writes to r0 are ignored
//                       and r0 is never busy.
//
//   Ports
//     CLK, RST_N            : clock (rising edge) and async active-low reset
//     WE0/In_Addr0/Data_in0 : write port 0 (low priority)
//     WE1/In_Addr1/Data_in1 : write port 1 (high priority)
//     Out_Addr1/Out_Addr2   : read addresses A/B
//     Data_out1/Data_out2   : read data A/B (combinational)
//     Busy1/Busy2           : busy bits of Out_Addr1/Out_Addr2 (combinational)
//     Rsv_En/Rsv_Addr       : reserve (mark busy) a register
//     Rsv_Waw               : registered; high for one cycle after a
//                             reservation hit a register that was already busy
//
//   Optional build macro
//     REGFILE_BYPASS_EN : reads that match a write in the same cycle return
//                         the write data (port 1 over port 0). Busy then
//                         reflects only a reservation in that same cycle.
module regfile_2w2r_sb #(
  parameter int unsigned num_bit_of_data = 32,
  parameter int unsigned num_bit_of_addr = 5,
  parameter bit          ZERO_REG        = 1'b1
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       WE0,
  input  logic [num_bit_of_addr-1:0] In_Addr0,
  input  logic [num_bit_of_data-1:0] Data_in0,
  input  logic                       WE1,
  input  logic [num_bit_of_addr-1:0] In_Addr1,
  input  logic [num_bit_of_data-1:0] Data_in1,
  input  logic [num_bit_of_addr-1:0] Out_Addr1,
  input  logic [num_bit_of_addr-1:0] Out_Addr2,
  output logic [num_bit_of_data-1:0] Data_out1,
  output logic [num_bit_of_data-1:0] Data_out2,
  output logic                       Busy1,
  output logic                       Busy2,
  input  logic                       Rsv_En,
  input  logic [num_bit_of_addr-1:0] Rsv_Addr,
  output logic                       Rsv_Waw
);

  localparam int unsigned DEPTH = 2 ** num_bit_of_addr;

  logic [num_bit_of_data-1:0] regs [DEPTH];
  logic [DEPTH-1:0]           busy;
  logic [DEPTH-1:0]           busy_next;
  logic                       rsv_waw_q;
  logic                       rsv_waw_next;

  // Requests after the zero-register rule has been applied.
  logic we0_ok, we1_ok, rsv_ok;

  // One-hot per-register select for each write port and the reservation.
  logic [DEPTH-1:0] wr_sel0, wr_sel1, rsv_sel;

  always_comb begin
    we0_ok = WE0    && !(ZERO_REG && (In_Addr0 == '0));
    we1_ok = WE1    && !(ZERO_REG && (In_Addr1 == '0));
    rsv_ok = Rsv_En && !(ZERO_REG && (Rsv_Addr == '0));

    wr_sel0 = we0_ok ? (DEPTH'(1) << In_Addr0) : '0;
    wr_sel1 = we1_ok ? (DEPTH'(1) << In_Addr1) : '0;
    rsv_sel = rsv_ok ? (DEPTH'(1) << Rsv_Addr) : '0;
  end

  // Any write to a register clears its busy bit. A reservation in the same
  // cycle then sets the bit again, because the newer producer wins.
  always_comb begin
    busy_next    = (busy & ~(wr_sel0 | wr_sel1)) | rsv_sel;
    rsv_waw_next = rsv_ok && busy[Rsv_Addr];
  end

  // Register storage. When both ports write the same register, port 1 wins.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (wr_sel1[i]) begin
          regs[i] <= Data_in1;
        end else if (wr_sel0[i]) begin
          regs[i] <= Data_in0;
        end
      end
    end
  end

  // Scoreboard and the write-after-write flag.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      busy      <= '0;
      rsv_waw_q <= 1'b0;
    end else begin
      busy      <= busy_next;
      rsv_waw_q <= rsv_waw_next;
    end
  end

  assign Rsv_Waw = rsv_waw_q;

  // Read ports.
  logic [num_bit_of_addr-1:0] rd_addr [2];
  logic [num_bit_of_data-1:0] rd_data [2];
  logic                       rd_busy [2];

  assign rd_addr[0] = Out_Addr1;
  assign rd_addr[1] = Out_Addr2;

  always_comb begin
    for (int unsigned p = 0; p < 2; p++) begin
      rd_data[p] = regs[rd_addr[p]];
      rd_busy[p] = busy[rd_addr[p]];
`ifdef REGFILE_BYPASS_EN
      // Bypass is held off during reset so that reads stay zero there.
      if (RST_N && WE1 && (In_Addr1 == rd_addr[p])) begin
        rd_data[p] = Data_in1;
        rd_busy[p] = Rsv_En && (Rsv_Addr == rd_addr[p]);
      end else if (RST_N && WE0 && (In_Addr0 == rd_addr[p])) begin
        rd_data[p] = Data_in0;
        rd_busy[p] = Rsv_En && (Rsv_Addr == rd_addr[p]);
      end
`endif
      if (ZERO_REG && (rd_addr[p] == '0)) begin
        rd_data[p] = '0;
        rd_busy[p] = 1'b0;
      end
    end
  end

  assign Data_out1 = rd_data[0];
  assign Data_out2 = rd_data[1];
  assign Busy1     = rd_busy[0];
  assign Busy2     = rd_busy[1];

endmodule
